// File: rtl/alu_seq.sv
// Registered ALU with single-cycle logic/arithmetic ops and iterative MUL/DIV.
// One op is issued per start pulse; done pulses when result and flags are valid.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       code,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             div_by_zero
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_reg, state_next;
    logic               mul_reg, mul_next;
    logic [CW-1:0]      cnt_reg, cnt_next;
    logic [2*WIDTH-1:0] acc_reg, acc_next;
    logic [2*WIDTH-1:0] mcand_reg, mcand_next;
    logic [WIDTH-1:0]   work_reg, work_next;
    logic [WIDTH-1:0]   divisor_reg, divisor_next;
    logic [WIDTH-1:0]   result_reg, result_next;
    logic [WIDTH-1:0]   remainder_reg, remainder_next;
    logic               done_reg, done_next;
    logic               zero_reg, zero_next;
    logic               carry_reg, carry_next;
    logic               overflow_reg, overflow_next;
    logic               dbz_reg, dbz_next;

    logic [WIDTH:0]     sum_ext, diff_ext;
    logic [2*WIDTH-1:0] mul_acc;
    logic [WIDTH:0]     div_shifted, div_trial;
    logic [WIDTH-1:0]   rem_step, quot_step;

    assign sum_ext  = {1'b0, operand1} + {1'b0, operand2};
    assign diff_ext = {1'b0, operand1} - {1'b0, operand2};

    // MUL: work_reg holds the multiplier, consumed LSB first; mcand_reg shifts left.
    assign mul_acc = acc_reg + (work_reg[0] ? mcand_reg : '0);

    // DIV: work_reg holds dividend bits shifting out MSB first, quotient bits shifting in.
    assign div_shifted = {acc_reg[WIDTH-1:0], work_reg[WIDTH-1]};
    assign div_trial   = div_shifted - {1'b0, divisor_reg};
    assign rem_step    = div_trial[WIDTH] ? div_shifted[WIDTH-1:0] : div_trial[WIDTH-1:0];
    assign quot_step   = {work_reg[WIDTH-2:0], ~div_trial[WIDTH]};

    always_comb begin
        state_next     = state_reg;
        mul_next       = mul_reg;
        cnt_next       = cnt_reg;
        acc_next       = acc_reg;
        mcand_next     = mcand_reg;
        work_next      = work_reg;
        divisor_next   = divisor_reg;
        result_next    = result_reg;
        remainder_next = remainder_reg;
        done_next      = 1'b0;
        zero_next      = zero_reg;
        carry_next     = carry_reg;
        overflow_next  = overflow_reg;
        dbz_next       = dbz_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    remainder_next = '0;
                    carry_next     = 1'b0;
                    overflow_next  = 1'b0;
                    dbz_next       = 1'b0;
                    done_next      = 1'b1;
                    case (code)
                        OP_ADD: begin
                            result_next   = sum_ext[WIDTH-1:0];
                            carry_next    = sum_ext[WIDTH];
                            overflow_next = (operand1[WIDTH-1] == operand2[WIDTH-1]) &&
                                            (sum_ext[WIDTH-1] != operand1[WIDTH-1]);
                        end
                        OP_SUB: begin
                            result_next   = diff_ext[WIDTH-1:0];
                            carry_next    = diff_ext[WIDTH];
                            overflow_next = (operand1[WIDTH-1] != operand2[WIDTH-1]) &&
                                            (diff_ext[WIDTH-1] != operand1[WIDTH-1]);
                        end
                        OP_AND: result_next = operand1 & operand2;
                        OP_OR:  result_next = operand1 | operand2;
                        OP_XOR: result_next = operand1 ^ operand2;
                        OP_SLL: result_next = operand1 << operand2[SHW-1:0];
                        default: begin
                            if (code != OP_MUL && operand2 == '0) begin
                                result_next    = '1;
                                remainder_next = operand1;
                                dbz_next       = 1'b1;
                            end else begin
                                // Multi-cycle: leave result/flags untouched until completion.
                                done_next      = 1'b0;
                                result_next    = result_reg;
                                remainder_next = remainder_reg;
                                carry_next     = carry_reg;
                                overflow_next  = overflow_reg;
                                dbz_next       = dbz_reg;
                                state_next     = RUN;
                                mul_next       = (code == OP_MUL);
                                cnt_next       = '0;
                                acc_next       = '0;
                                mcand_next     = {{WIDTH{1'b0}}, operand1};
                                work_next      = (code == OP_MUL) ? operand2 : operand1;
                                divisor_next   = operand2;
                            end
                        end
                    endcase
                end
            end
            RUN: begin
                cnt_next = cnt_reg + 1'b1;
                if (mul_reg) begin
                    acc_next   = mul_acc;
                    mcand_next = mcand_reg << 1;
                    work_next  = work_reg >> 1;
                end else begin
                    acc_next  = {{WIDTH{1'b0}}, rem_step};
                    work_next = quot_step;
                end
                if (cnt_reg == CW'(WIDTH - 1)) begin
                    state_next    = IDLE;
                    done_next     = 1'b1;
                    overflow_next = 1'b0;
                    dbz_next      = 1'b0;
                    if (mul_reg) begin
                        result_next    = mul_acc[WIDTH-1:0];
                        remainder_next = '0;
                        carry_next     = |mul_acc[2*WIDTH-1:WIDTH];
                    end else begin
                        result_next    = quot_step;
                        remainder_next = rem_step;
                        carry_next     = 1'b0;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (done_next)
            zero_next = (result_next == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            mul_reg       <= 1'b0;
            cnt_reg       <= '0;
            acc_reg       <= '0;
            mcand_reg     <= '0;
            work_reg      <= '0;
            divisor_reg   <= '0;
            result_reg    <= '0;
            remainder_reg <= '0;
            done_reg      <= 1'b0;
            zero_reg      <= 1'b0;
            carry_reg     <= 1'b0;
            overflow_reg  <= 1'b0;
            dbz_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            mul_reg       <= mul_next;
            cnt_reg       <= cnt_next;
            acc_reg       <= acc_next;
            mcand_reg     <= mcand_next;
            work_reg      <= work_next;
            divisor_reg   <= divisor_next;
            result_reg    <= result_next;
            remainder_reg <= remainder_next;
            done_reg      <= done_next;
            zero_reg      <= zero_next;
            carry_reg     <= carry_next;
            overflow_reg  <= overflow_next;
            dbz_reg       <= dbz_next;
        end
    end

    assign result      = result_reg;
    assign remainder   = remainder_reg;
    assign busy        = (state_reg == RUN);
    assign done        = done_reg;
    assign zero        = zero_reg;
    assign carry       = carry_reg;
    assign overflow    = overflow_reg;
    assign div_by_zero = dbz_reg;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: expected results are queued at issue and
// compared, together with done latency, whenever done is observed.
module tb_alu_seq;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   code;
    logic [W-1:0] operand1, operand2;
    logic [W-1:0] result, remainder;
    logic         busy, done, zero, carry, overflow, div_by_zero;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .code(code),
        .operand1(operand1), .operand2(operand2),
        .result(result), .remainder(remainder), .busy(busy), .done(done),
        .zero(zero), .carry(carry), .overflow(overflow), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] rem;
        logic         z, c, v, d;
        int           done_cycle;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cycle);
        end
    endtask

    function automatic exp_t model(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   sv;
        logic [2*W-1:0] p;
        e.rem = '0; e.c = 1'b0; e.v = 1'b0; e.d = 1'b0; e.done_cycle = 0;
        case (c)
            3'b000: begin
                e.res = a + b;
                e.c   = (int'(a) + int'(b)) > 65535;
                sv    = int'($signed(a)) + int'($signed(b));
                e.v   = (sv > 32767) || (sv < -32768);
            end
            3'b001: begin
                e.res = a - b;
                e.c   = a < b;
                sv    = int'($signed(a)) - int'($signed(b));
                e.v   = (sv > 32767) || (sv < -32768);
            end
            3'b010: e.res = a & b;
            3'b011: e.res = a | b;
            3'b100: e.res = a ^ b;
            3'b101: e.res = a << b[3:0];
            3'b110: begin
                p     = {16'h0, a} * {16'h0, b};
                e.res = p[W-1:0];
                e.c   = p[2*W-1:W] != '0;
            end
            default: begin
                if (b == '0) begin
                    e.res = '1; e.rem = a; e.d = 1'b1;
                end else begin
                    e.res = a / b; e.rem = a % b;
                end
            end
        endcase
        e.z = (e.res == '0);
        return e;
    endfunction

    // Called at a negedge; drives for one cycle and returns at the next negedge.
    task automatic issue(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit expect_it);
        exp_t e;
        start = 1'b1; code = c; operand1 = a; operand2 = b;
        if (expect_it) begin
            e = model(c, a, b);
            e.done_cycle = cycle + 1 + ((c == 3'b110 || (c == 3'b111 && b != '0)) ? W : 0);
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        $display("issue code=%0d a=0x%04h b=0x%04h at cycle %0d", c, a, b, cycle - 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < W + 4) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic run_op(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        issue(c, a, b, 1'b1);
        wait_done();
    endtask

    task automatic drain();
        repeat (W + 4) @(negedge clk);
        chk("sb_drain", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("remainder", remainder, e.rem);
                chk("zero", zero, e.z);
                chk("carry", carry, e.c);
                chk("overflow", overflow, e.v);
                chk("div_by_zero", div_by_zero, e.d);
                chk("done_cycle", cycle, e.done_cycle);
                chk("busy_at_done", busy, 0);
                $display("done result=0x%04h rem=0x%04h z=%0b c=%0b v=%0b dz=%0b cycle=%0d",
                         result, remainder, zero, carry, overflow, div_by_zero, cycle);
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; code = '0; operand1 = '0; operand2 = '0;
        repeat (3) @(negedge clk);
        chk("rst_result", result, 0);
        chk("rst_flags", {busy, done, zero, carry, overflow, div_by_zero}, 0);
        rst = 1'b0;
        @(negedge clk);

        run_op(3'b010, 16'h000F, 16'h003C);
        run_op(3'b011, 16'h000F, 16'h003C);
        run_op(3'b000, 16'h0005, 16'h0003);
        run_op(3'b001, 16'h0005, 16'h0003);
        run_op(3'b000, 16'h7FFF, 16'h0001);
        run_op(3'b000, 16'hFFFF, 16'h0001);
        run_op(3'b001, 16'h0003, 16'h0005);
        run_op(3'b001, 16'h8000, 16'h0001);
        run_op(3'b100, 16'hA5A5, 16'h0FF0);
        run_op(3'b101, 16'h0003, 16'h0014);
        drain();

        // MUL with an ADD start attempted while busy
        issue(3'b110, 16'h0012, 16'h0034, 1'b1);
        chk("mul_busy", busy, 1);
        repeat (4) @(negedge clk);
        start = 1'b1; code = 3'b000; operand1 = 16'h1111; operand2 = 16'h2222;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("mul_busy_late", {busy, done}, 2'b10);
        wait_done();
        drain();

        run_op(3'b110, 16'h0100, 16'h0100);
        drain();
        run_op(3'b110, 16'hFFFF, 16'hFFFF);
        drain();
        run_op(3'b111, 16'h0064, 16'h0007);
        drain();
        run_op(3'b111, 16'h0064, 16'h0000);
        drain();

        // Reset while a MUL is in flight: no done may follow for it
        issue(3'b110, 16'h0033, 16'h0044, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_state", {busy, done}, 0);
        chk("abort_result", result, 0);
        rst = 1'b0;
        drain();
        run_op(3'b000, 16'h0001, 16'h0001);
        drain();

        // Back-to-back: new op issued in the cycle done is high
        issue(3'b110, 16'h0007, 16'h0009, 1'b1);
        wait_done();
        run_op(3'b000, 16'h1234, 16'h4321);
        run_op(3'b001, 16'h0000, 16'h0001);
        run_op(3'b111, 16'hFFFF, 16'h0010);
        drain();

        for (int i = 0; i < 12; i++) begin
            logic [2:0]   rc;
            logic [W-1:0] ra, rb;
            rc = 3'($urandom_range(0, 7));
            ra = W'($urandom);
            rb = W'($urandom);
            run_op(rc, ra, rb);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
